// File: rtl/ohm_pkg.sv
// Shared types, result codes and ADC-format helpers for the igniter resistance calculator.
package ohm_pkg;

  localparam int unsigned OHM_ADC_W = 12;
  localparam int unsigned OHM_MAG_W = OHM_ADC_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } ohm_state_e;

  localparam logic [OHM_ADC_W-1:0] R_ZERO_CODE = 12'h7FF;
  localparam logic [OHM_ADC_W-1:0] R_OPEN_CODE = 12'h023;

  // A set sign bit means the voltage reads below zero; treat it as no charge.
  function automatic logic [OHM_MAG_W-1:0] adc_to_mag_v(input logic [OHM_ADC_W-1:0] raw);
    logic [OHM_MAG_W-1:0] mag;
    mag = raw[OHM_MAG_W-1:0] ^ {OHM_MAG_W{1'b1}};
    return raw[OHM_ADC_W-1] ? '0 : mag;
  endfunction

  // Negative or zero current is forced to 1 so the divisor is never zero.
  function automatic logic [OHM_MAG_W-1:0] adc_to_mag_i(input logic [OHM_ADC_W-1:0] raw);
    logic [OHM_MAG_W-1:0] mag;
    mag = raw[OHM_MAG_W-1:0] ^ {OHM_MAG_W{1'b1}};
    return (raw[OHM_ADC_W-1] || (mag == '0)) ? OHM_MAG_W'(1) : mag;
  endfunction

  function automatic logic [OHM_ADC_W-1:0] mag_to_adc(input logic [OHM_MAG_W-1:0] field);
    return {1'b0, field ^ {OHM_MAG_W{1'b1}}};
  endfunction

endpackage

// File: rtl/ohm_r4_divider.sv
// Iterative radix-4 restoring divider: quo = (num << QEXT) / den, one base-4 digit per cycle.
module ohm_r4_divider #(
  parameter int unsigned NW   = 27,
  parameter int unsigned DW   = 11,
  parameter int unsigned QEXT = 3,
  localparam int unsigned QW  = NW + QEXT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          done,
  output logic [QW-1:0] quo
);

  localparam int unsigned ITER = (QW + 1) / 2;
  localparam int unsigned PW   = 2 * ITER;
  localparam int unsigned RW   = DW + 2;
  localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;

  // acc holds the unconsumed dividend in its upper bits and the quotient digits in its lower bits.
  logic [PW-1:0] acc_q, acc_d, acc_step;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] den_q, den_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  logic [RW-1:0] rem4, d1, d2, d3, rem_n;
  logic [1:0]    digit;
  logic          unused_rem_hi;

  always_comb begin
    rem4 = {rem_q, acc_q[PW-1 -: 2]};
    d1   = RW'(den_q);
    d2   = d1 << 1;
    d3   = d1 + d2;
    if (rem4 >= d3) begin
      digit = 2'd3;
      rem_n = rem4 - d3;
    end else if (rem4 >= d2) begin
      digit = 2'd2;
      rem_n = rem4 - d2;
    end else if (rem4 >= d1) begin
      digit = 2'd1;
      rem_n = rem4 - d1;
    end else begin
      digit = 2'd0;
      rem_n = rem4;
    end
    acc_step = {acc_q[PW-3:0], digit};
  end

  // The remainder is always below den, so its top two working bits are zero.
  assign unused_rem_hi = ^rem_n[RW-1:DW];

  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    den_d = den_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      acc_d = PW'(num) << QEXT;
      rem_d = '0;
      den_d = den;
      cnt_d = CW'(ITER - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = acc_step;
      rem_d = rem_n[DW-1:0];
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // Quotient is presented combinationally during the final digit cycle so the caller can register it.
  assign done = run_q && (cnt_q == '0);
  assign quo  = acc_step[QW-1:0];

endmodule

// File: rtl/ohm_calc_mc.sv
// Multi-channel igniter resistance calculator R = V*SCALE/I on a shared radix-4 divider.
// Optional open-circuit reporting is enabled by defining OHM_CALC_OPEN_DETECT_EN.
module ohm_calc_mc
  import ohm_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned ADC_W   = OHM_ADC_W,
  parameter int unsigned SCALE   = 42089,
  parameter int unsigned SCALE_W = 16,
  parameter int unsigned QEXT    = 3,
  parameter int unsigned OUT_LSB = 8,
  parameter int unsigned I_MIN   = 32,
  parameter int unsigned V_OPEN  = 64,
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH_W-1:0]      in_ch,
  input  logic [ADC_W-1:0]     v_in,
  input  logic [ADC_W-1:0]     i_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [ADC_W-1:0]     r_out,
  output logic [NCH*ADC_W-1:0] r_hold,
  output logic                 busy
);

  localparam int unsigned M  = ADC_W - 1;
  localparam int unsigned NW = M + SCALE_W;
  localparam int unsigned QW = NW + QEXT;

  localparam logic [SCALE_W-1:0] SCALE_L  = SCALE_W'(SCALE);
  localparam logic [M-1:0]       I_MIN_L  = M'(I_MIN);
  localparam logic [M-1:0]       V_OPEN_L = M'(V_OPEN);

`ifdef OHM_CALC_OPEN_DETECT_EN
  localparam bit OPEN_EN = 1'b1;
`else
  localparam bit OPEN_EN = 1'b0;
`endif

  ohm_state_e state_q, state_d;

  logic [CH_W-1:0]      ch_q, ch_d;
  logic [NW-1:0]        n_q, n_d;
  logic [M-1:0]         i_q, i_d;
  logic                 v_open_q, v_open_d;
  logic                 start_q, start_d;
  logic [CH_W-1:0]      out_ch_q, out_ch_d;
  logic [ADC_W-1:0]     r_out_q, r_out_d;
  logic [NCH*ADC_W-1:0] r_hold_q, r_hold_d;

  logic [M-1:0]     v_mag;
  logic             div_done;
  logic [QW-1:0]    quo;
  logic             low_i, ovf;
  logic [M-1:0]     field;
  logic [ADC_W-1:0] r_sel;
  logic             unused_quo_lsbs;

  assign v_mag = adc_to_mag_v(v_in);

  // Start is delayed one cycle so the V*SCALE product is taken from a register.
  ohm_r4_divider #(
    .NW   (NW),
    .DW   (M),
    .QEXT (QEXT)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .start (start_q),
    .num   (n_q),
    .den   (i_q),
    .done  (div_done),
    .quo   (quo)
  );

  assign low_i           = (i_q <= I_MIN_L);
  assign ovf             = |quo[QW-1:OUT_LSB+M];
  assign field           = quo[OUT_LSB +: M];
  assign unused_quo_lsbs = ^quo[OUT_LSB-1:0];

  always_comb begin
    if (low_i) begin
      r_sel = v_open_q ? R_OPEN_CODE : R_ZERO_CODE;
    end else if (ovf) begin
      r_sel = mag_to_adc({M{1'b1}});
    end else begin
      r_sel = mag_to_adc(field);
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    n_d      = n_q;
    i_d      = i_q;
    v_open_d = v_open_q;
    start_d  = 1'b0;
    out_ch_d = out_ch_q;
    r_out_d  = r_out_q;
    r_hold_d = r_hold_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = DIV;
          ch_d     = in_ch;
          n_d      = {{SCALE_W{1'b0}}, v_mag} * {{M{1'b0}}, SCALE_L};
          i_d      = adc_to_mag_i(i_in);
          v_open_d = OPEN_EN && (v_mag > V_OPEN_L);
          start_d  = 1'b1;
        end
      end
      DIV: begin
        if (div_done) begin
          state_d  = DONE;
          out_ch_d = ch_q;
          r_out_d  = r_sel;
          // Out-of-range tags match no channel and leave the hold registers untouched.
          for (int n = 0; n < int'(NCH); n++) begin
            if (ch_q == CH_W'(n)) begin
              r_hold_d[n*ADC_W +: ADC_W] = r_sel;
            end
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      n_q      <= '0;
      i_q      <= '0;
      v_open_q <= 1'b0;
      start_q  <= 1'b0;
      out_ch_q <= '0;
      r_out_q  <= '0;
      r_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      n_q      <= n_d;
      i_q      <= i_d;
      v_open_q <= v_open_d;
      start_q  <= start_d;
      out_ch_q <= out_ch_d;
      r_out_q  <= r_out_d;
      r_hold_q <= r_hold_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_ch    = out_ch_q;
  assign r_out     = r_out_q;
  assign r_hold    = r_hold_q;

endmodule

// File: tb/tb_ohm_calc_mc.sv
// Scoreboard bench for ohm_calc_mc: directed vectors, handshake/reset cases and a random sweep.
`timescale 1ns/1ps
module tb_ohm_calc_mc;

  localparam int NCH   = 4;
  localparam int ADC_W = 12;
  localparam int CH_W  = 2;

`ifdef OHM_CALC_OPEN_DETECT_EN
  localparam logic [11:0] LOW_I_HIGH_V = 12'h023;
`else
  localparam logic [11:0] LOW_I_HIGH_V = 12'h7FF;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [CH_W-1:0]      in_ch = '0;
  logic [ADC_W-1:0]     v_in = '0;
  logic [ADC_W-1:0]     i_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [CH_W-1:0]      out_ch;
  logic [ADC_W-1:0]     r_out;
  logic [NCH*ADC_W-1:0] r_hold;
  logic                 busy;

  ohm_calc_mc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .v_in      (v_in),
    .i_in      (i_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .r_out     (r_out),
    .r_hold    (r_hold),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [ADC_W-1:0] r;
  } exp_t;

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [11:0]     v;
    logic [11:0]     i;
    logic [11:0]     r;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [11:0] exp_hold[NCH];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NCH*ADC_W-1:0] hold_vec();
    logic [NCH*ADC_W-1:0] hv;
    for (int n = 0; n < NCH; n++) hv[n*ADC_W +: ADC_W] = exp_hold[n];
    return hv;
  endfunction

  // Golden model in plain wide integer arithmetic.
  function automatic logic [11:0] model(input logic [11:0] v_raw, input logic [11:0] i_raw);
    logic [10:0]     vm, im, fld;
    longint unsigned v, i, q;
    vm = v_raw[10:0] ^ 11'h7FF;
    im = i_raw[10:0] ^ 11'h7FF;
    v  = v_raw[11] ? 64'd0 : 64'(vm);
    i  = (i_raw[11] || im == 11'd0) ? 64'd1 : 64'(im);
    if (i <= 64'd32) begin
`ifdef OHM_CALC_OPEN_DETECT_EN
      if (v > 64'd64) return 12'h023;
`endif
      return 12'h7FF;
    end
    q = (v * 64'd42089 * 64'd8) / i;
    if (q >= 64'd524288) return 12'h000;
    fld = 11'(q >> 8);
    return {1'b0, fld ^ 11'h7FF};
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ch %0d r 0x%0h, expected no result", out_ch, r_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_ch", 64'(out_ch), 64'(mon_e.ch));
        chk("r_out", 64'(r_out), 64'(mon_e.r));
        exp_hold[mon_e.ch] = mon_e.r;
        chk("r_hold", 64'(r_hold), 64'(hold_vec()));
      end
    end
  end

  task automatic send(input logic [CH_W-1:0] ch, input logic [11:0] v, input logic [11:0] i,
                      input bit push, input logic [11:0] r_exp);
    int   n;
    bit   rdy;
    exp_t e;
    n     = 0;
    rdy   = 1'b0;
    in_ch = ch;
    v_in  = v;
    i_in  = i;
    in_valid = 1'b1;
    while (!rdy && n <= 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected acceptance", n);
    end else if (push) begin
      e.ch = ch;
      e.r  = r_exp;
      sb_q.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[7];
  int   lat;
  int   stale;

  initial begin
    vecs[0] = '{ch: 2'd1, v: 12'h79B, i: 12'h800, r: LOW_I_HIGH_V};
    vecs[1] = '{ch: 2'd1, v: 12'h7F5, i: 12'h800, r: 12'h7FF};
    vecs[2] = '{ch: 2'd3, v: 12'h000, i: 12'h7DE, r: 12'h000};
    vecs[3] = '{ch: 2'd0, v: 12'h000, i: 12'h7DF, r: LOW_I_HIGH_V};
    vecs[4] = '{ch: 2'd0, v: 12'h800, i: 12'h79B, r: 12'h7FF};
    vecs[5] = '{ch: 2'd2, v: 12'h7CD, i: 12'h737, r: 12'h6B7};
    vecs[6] = '{ch: 2'd3, v: 12'h7F5, i: 12'h7FF, r: 12'h7FF};
    for (int n = 0; n < NCH; n++) exp_hold[n] = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_r_out", 64'(r_out), 64'd0);
    chk("rst_r_hold", 64'(r_hold), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Nominal case and accept-to-valid latency
    @(posedge clk);
    #1;
    send(2'd2, 12'h79B, 12'h79B, 1'b1, 12'h2DC);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd16);
    drain();
    chk("r_hold_ch2", 64'(r_hold[2*ADC_W +: ADC_W]), 64'h2DC);

    // Low-current, saturation and boundary vectors
    foreach (vecs[k]) begin
      send(vecs[k].ch, vecs[k].v, vecs[k].i, 1'b1, vecs[k].r);
      drain();
    end

    // Back-pressure in DONE
    out_ready = 1'b0;
    send(2'd1, 12'h7CD, 12'h737, 1'b1, 12'h6B7);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'd16);
    in_ch    = 2'd3;
    v_in     = 12'h79B;
    i_in     = 12'h79B;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_ch", 64'(out_ch), 64'd1);
      chk("bp_r_out", 64'(r_out), 64'h6B7);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ready", 64'(in_ready), 64'd1);
    mon_e.ch = 2'd3;
    mon_e.r  = 12'h2DC;
    sb_q.push_back(mon_e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accepted", 64'(busy), 64'd1);
    drain();

    // Reset in the middle of a division
    send(2'd0, 12'h79B, 12'h79B, 1'b0, 12'h000);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int n = 0; n < NCH; n++) exp_hold[n] = '0;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_r_out", 64'(r_out), 64'd0);
    chk("mid_rst_r_hold", 64'(r_hold), 64'd0);
    stale = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_result", 64'(stale), 64'd0);
    @(posedge clk);
    #1;

    // Random sweep against the model
    for (int k = 0; k < 300; k++) begin
      logic [CH_W-1:0] ch;
      logic [11:0]     v, i;
      ch = CH_W'($urandom_range(0, NCH - 1));
      v  = 12'($urandom);
      i  = 12'($urandom);
      if ((k % 4) == 0) i[11] = 1'b0;
      send(ch, v, i, 1'b1, model(v, i));
    end
    drain();
    chk("final_r_hold", 64'(r_hold), 64'(hold_vec()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
